// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequencer for one signed INT8 MAC lane
// Clears the MAC, streams K operand pairs, waits out acc latency, returns the sum.
module mac_seq_ctrl #(
  parameter int KW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  output logic [7:0]    mac_a,
  output logic [7:0]    mac_b,
  output logic          mac_en,
  output logic          mac_clr,
  input  logic [31:0]   mac_acc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_WAIT, S_OUTPUT} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] counter, k_reg;
  logic          abort_act, last_pair;

  assign abort_act = abort && (state != S_IDLE);
  assign last_pair = (counter == k_reg - KW'(1));
  assign mac_a     = in_a;
  assign mac_b     = in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_CLEAR;
        S_CLEAR:  state_nxt = (k_reg != '0) ? S_RUN : S_WAIT;
        S_RUN:    if (mac_en && last_pair) state_nxt = S_WAIT;
        S_WAIT:   state_nxt = S_OUTPUT;
        S_OUTPUT: if (out_ready) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Abort drops in_ready in its cycle so no pair is consumed while the MAC clears.
  always_comb begin
    busy      = (state != S_IDLE);
    in_ready  = (state == S_RUN) && !abort;
    mac_en    = (state == S_RUN) && !abort && in_valid;
    mac_clr   = (state == S_CLEAR) || abort_act;
    out_valid = (state == S_OUTPUT);
    done      = (state == S_OUTPUT) && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      k_reg    <= '0;
      out_data <= '0;
    end else begin
      if (abort_act) begin
        counter <= '0;
      end else if (state == S_IDLE && start) begin
        counter <= '0;
        k_reg   <= k_len;
      end else if (mac_en) begin
        counter <= counter + KW'(1);
      end
      if (state == S_WAIT && !abort) out_data <= mac_acc;
    end
  end

`ifndef SYNTHESIS
  a_clr_en_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mac_clr && mac_en));
  a_out_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                   (out_valid && !out_ready) |=> $stable(out_data));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n) counter <= k_reg);
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl with a behavioural MAC
module tb_mac_seq_ctrl;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy, done;
  logic          in_valid, in_ready;
  logic [7:0]    in_a, in_b, mac_a, mac_b;
  logic          mac_en, mac_clr;
  logic [31:0]   mac_acc;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;

  logic signed [31:0] acc;
  logic signed [15:0] prod;

  int total = 0, bad = 0, cyc = 0, en_cnt = 0;
  int s_cyc, last_cyc, exp_sum;
  int expq[$];
  int va[256], vb[256];

  mac_seq_ctrl #(.KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference MAC: sync clear, enable, registered accumulate, shares rst_n.
  assign prod    = $signed(mac_a) * $signed(mac_b);
  assign mac_acc = acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= 32'sd0;
    else if (mac_clr) acc <= 32'sd0;
    else if (mac_en)  acc <= acc + {{16{prod[15]}}, prod};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (mac_en) en_cnt++;
      if (out_valid && out_ready) begin
        chk("done_on_handshake", done, 1);
        chk("sb_pending", expq.size() > 0, 1);
        if (expq.size() > 0) chk("result", out_data, expq.pop_front());
      end else if (done) begin
        chk("done_spurious", done, 0);
      end
    end
  end

  task automatic do_start(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    s_cyc = cyc;
    en_cnt = 0;
    #1;
    chk("idle_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("clear_pulse", mac_clr, 1);
    chk("clear_no_en", mac_en, 0);
    chk("clear_busy", busy, 1);
  endtask

  task automatic feed(input int n, input int gap_pct, input int start_at);
    int sent = 0;
    int budget = 0;
    bit fired = 1'b0;
    while (sent < n && budget < 3000) begin
      @(negedge clk);
      in_a     = 8'(va[sent]);
      in_b     = 8'(vb[sent]);
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      if (!fired && sent == start_at) begin
        start = 1'b1;
        k_len = KW'(2);
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        sent++;
        last_cyc = cyc;
      end
      budget++;
    end
    start = 1'b0;
    chk("feed_complete", sent, n);
  endtask

  task automatic wait_out(input int ref_c, input int lat, input string tag);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, cyc - ref_c, lat);
  endtask

  task automatic finish_out();
    @(negedge clk);
    #1;
    chk("valid_drop", out_valid, 0);
    chk("done_one_cycle", done, 0);
    chk("back_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; abort = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic 4-element dot product
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
    expq.push_back(70);
    do_start(4);
    feed(4, 0, -1);
    wait_out(last_cyc, 2, "basic");
    finish_out();
    chk("basic_en_cnt", en_cnt, 4);

    // max magnitude, then a second run proving the clear
    for (int i = 0; i < 256; i++) begin va[i] = -128; vb[i] = -128; end
    expq.push_back(4194304);
    do_start(256);
    feed(256, 0, -1);
    wait_out(last_cyc, 2, "maxmag");
    finish_out();
    for (int i = 0; i < 3; i++) vb[i] = 127;
    expq.push_back(-48768);
    do_start(3);
    feed(3, 0, -1);
    wait_out(last_cyc, 2, "signed");
    finish_out();

    // input gaps and output backpressure
    for (int i = 0; i < 5; i++) begin va[i] = 2; vb[i] = -3; end
    out_ready = 1'b0;
    expq.push_back(-30);
    do_start(5);
    feed(5, 40, -1);
    wait_out(last_cyc, 2, "gaps");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_stable", out_data, -30);
      chk("bp_no_done", done, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_done_on_ready", done, 1);
    finish_out();

    // K=0 yields 0 at start+3
    expq.push_back(0);
    do_start(0);
    wait_out(s_cyc, 3, "k0");
    finish_out();

    // start while busy is ignored: exactly 8 pairs consumed
    exp_sum = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = i * 9 - 30;
      vb[i] = 17 - i * 5;
      exp_sum += va[i] * vb[i];
    end
    expq.push_back(exp_sum);
    do_start(8);
    feed(8, 0, 4);
    wait_out(last_cyc, 2, "busy_start");
    finish_out();
    chk("busy_start_en_cnt", en_cnt, 8);

    // abort after 3 of 6 pairs
    for (int i = 0; i < 6; i++) begin va[i] = 3; vb[i] = 4; end
    do_start(6);
    feed(3, 0, -1);
    @(negedge clk);
    abort = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("abort_clr", mac_clr, 1);
    chk("abort_no_en", mac_en, 0);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_clr_once", mac_clr, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_valid", out_valid, 0);
    end
    for (int i = 0; i < 2; i++) begin va[i] = 1; vb[i] = 1; end
    expq.push_back(2);
    do_start(2);
    feed(2, 0, -1);
    wait_out(last_cyc, 2, "post_abort");
    finish_out();

    // async reset mid-RUN
    for (int i = 0; i < 10; i++) begin va[i] = 7; vb[i] = -9; end
    do_start(10);
    feed(3, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_mac_en", mac_en, 0);
    chk("arst_mac_clr", mac_clr, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_ready", in_ready, 0);
    va[0] = 5; vb[0] = 5;
    expq.push_back(25);
    do_start(1);
    feed(1, 0, -1);
    wait_out(last_cyc, 2, "post_reset");
    finish_out();

    repeat (3) @(negedge clk);
    chk("sb_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for a single signed INT8 MAC unit. The MAC has sync clear, enable, 1-cycle registered accumulate and a 32-bit acc output.
- Takes a start command with a runtime dot-product length. Clears the MAC, streams K operand pairs through it under valid/ready, waits out the accumulator latency, then presents the 32-bit result on a valid/ready output.
- Sits between the layer scheduler / operand buffers and one MAC lane of the CNN engine.

Parameters:
- KW, 16, width of k_len and the element counter; max K = 2^KW-1.
- Sum cannot overflow: 65535 × 16384 < 2^31.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command pulse; sampled only in IDLE
- k_len  in  KW  dot-product length, latched on accepted start
- abort  in  1  sync abort, any state
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse on result handshake
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts operand pair
- in_a  in  8  signed activation
- in_b  in  8  signed weight
- mac_a  out  8  to MAC a (combinational pass of in_a)
- mac_b  out  8  to MAC b (combinational pass of in_b)
- mac_en  out  1  to MAC en
- mac_clr  out  1  to MAC clr
- mac_acc  in  32  MAC accumulator output
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_data  out  32  signed dot-product result, registered

Behaviour:
- Reset (async):
  - state=IDLE, counter=0, k_reg=0, out_data=0.
  - busy, done, in_ready, mac_en, mac_clr and out_valid are all 0.
- States: IDLE, CLEAR, RUN, WAIT, OUTPUT.
- IDLE:
  - On start=1, latch k_reg=k_len, counter=0, go to CLEAR.
  - in_ready=0.
- CLEAR:
  - Exactly 1 cycle with mac_clr=1 and mac_en=0.
  - Next state is RUN if k_reg≠0, else WAIT (K=0 yields 0).
- RUN:
  - in_ready=1 and mac_en = in_valid & in_ready. mac_clr=0.
  - Each accepted pair increments counter.
  - Accepting the pair with counter==k_reg-1 moves to WAIT.
  - in_valid gaps stall the counter; mac_en=0 while stalled, so acc holds.
- WAIT:
  - 1 cycle, in_ready=0, mac_en=0. mac_acc now includes the last product.
  - Register out_data=mac_acc and go to OUTPUT.
- OUTPUT:
  - out_valid=1. out_data is held stable until out_ready=1.
  - On handshake: done=1 for that cycle (combinational on handshake), out_valid drops next cycle, state=IDLE.
- Latency:
  - Last accepted pair in cycle t gives out_valid=1 in cycle t+2.
  - start in cycle s with k_len=0 gives out_valid=1 in cycle s+3.
- in_ready is 0 in every state other than RUN.
- mac_a and mac_b always pass through in_a and in_b; they are meaningful only when mac_en=1.
- start while busy: ignored, and k_reg is unchanged.
- start on the same cycle as the OUTPUT handshake: ignored. start is sampled only in IDLE.
- abort:
  - Highest priority after reset.
  - From any non-IDLE state: next state IDLE, mac_clr=1 in the abort cycle, out_valid→0, no done pulse, counter=0.
  - Aborting in IDLE has no effect.
- Simultaneous abort and out handshake in OUTPUT: handshake completes (done=1); state goes to IDLE either way.
- Reset mid-operation: all state returns to reset values immediately. The MAC is reset by the same rst_n.
- Assertions (simulation only):
  - mac_clr and mac_en never both 1.
  - out_data stable while out_valid & !out_ready.
  - counter ≤ k_reg.

Test Plan:
- Basic dot product: start, k_len=4, a={1,2,3,4}, b={5,6,7,8}, in_valid continuous, out_ready=1. Expect out_data=70, out_valid 2 cycles after the 4th accept, done 1 cycle.
- Signed/max magnitude: k_len=256, all a=-128, b=-128. Expect out_data=4194304. Then a second run with a=-128, b=127, K=3. Expect out_data=-48768, proving the clear between runs.
- Gaps and backpressure: k_len=5 with a random in_valid gap pattern, all pairs (2,-3). Expect -30. Hold out_ready=0 for 10 cycles: out_valid stays 1, out_data stable, done only on the ready cycle.
- K=0 and start-while-busy: k_len=0 gives out_data=0 at start+3. During a K=8 run, pulse start with k_len=2. Expect it ignored and exactly 8 pairs consumed.
- Abort mid-RUN: assert abort after 3 of 6 pairs. Expect IDLE next cycle, mac_clr=1 in the abort cycle, no out_valid, no done. A following K=2 run of (1,1) yields 2.
- Async reset mid-RUN: drop rst_n between clock edges. All outputs go to 0 immediately, and after release the controller is in IDLE with busy=0.
